// File: rtl/scan_test_ctrl.sv
// Directed scan-test sequencer for one chain: load pattern, capture, unload, compare.
// Optional MISR signature over unloaded bits is enabled by defining SCAN_CTRL_MISR_EN.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] pattern_i,
  input  logic [CHAIN_LEN-1:0] expect_i,
  input  logic                 func_val_i,
  input  logic [3:0]           cap_cycles_i,
  input  logic                 scan_out_i,
  output logic                 scan_en_o,
  output logic                 scan_in_o,
  output logic                 in_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CHAIN_LEN-1:0] response_o,
  output logic                 fail_o,
  output logic [7:0]           pat_count_o
`ifdef SCAN_CTRL_MISR_EN
  , output logic [15:0]        signature_o
`endif
);

  localparam int unsigned KW = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
  } state_t;

  state_t               state_q;
  logic [KW-1:0]        k_q;
  logic [3:0]           c_q;
  logic [3:0]           cap_q;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic                 fv_q;
  logic                 scan_en_q;
  logic                 scan_in_q;
  logic                 in_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CHAIN_LEN-1:0] response_q;
  logic                 fail_q;
  logic [7:0]           pat_count_q;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]          sig_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      cap_q       <= '0;
      pat_q       <= '0;
      exp_q       <= '0;
      fv_q        <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      in_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= '0;
      fail_q      <= 1'b0;
      pat_count_q <= '0;
`ifdef SCAN_CTRL_MISR_EN
      sig_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // pat_q holds the not-yet-presented bits, MSB aligned; the first bit goes out now
            pat_q      <= pattern_i << 1;
            scan_in_q  <= pattern_i[CHAIN_LEN-1];
            exp_q      <= expect_i;
            fv_q       <= func_val_i;
            cap_q      <= (cap_cycles_i == 4'd0) ? 4'd1 : cap_cycles_i;
            k_q        <= '0;
            response_q <= '0;
            scan_en_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (k_q == KW'(CHAIN_LEN - 1)) begin
            c_q       <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            in_q      <= fv_q;
            state_q   <= S_CAPTURE;
          end else begin
            k_q       <= k_q + 1'b1;
            scan_in_q <= pat_q[CHAIN_LEN-1];
            pat_q     <= pat_q << 1;
          end
        end
        S_CAPTURE: begin
          if (c_q == cap_q - 4'd1) begin
            k_q       <= '0;
            in_q      <= 1'b0;
            scan_en_q <= 1'b1;
            state_q   <= S_UNLOAD;
          end else begin
            c_q <= c_q + 4'd1;
          end
        end
        S_UNLOAD: begin
          response_q <= {response_q[CHAIN_LEN-2:0], scan_out_i};
`ifdef SCAN_CTRL_MISR_EN
          sig_q <= {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ scan_out_i};
`endif
          if (k_q == KW'(CHAIN_LEN - 1)) begin
            scan_en_q <= 1'b0;
            state_q   <= S_COMPARE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_COMPARE: begin
          // done and the new count become visible together in the DONE cycle
          fail_q      <= (response_q != exp_q);
          done_q      <= 1'b1;
          pat_count_q <= pat_count_q + 8'd1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign scan_en_o   = scan_en_q;
  assign scan_in_o   = scan_in_q;
  assign in_o        = in_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign response_o  = response_q;
  assign fail_o      = fail_q;
  assign pat_count_o = pat_count_q;
`ifdef SCAN_CTRL_MISR_EN
  assign signature_o = sig_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Self-checking bench for scan_test_ctrl: table scenarios, corner sequences and
// randomized passes against an arithmetic reference of the chain response.
module tb_scan_test_ctrl;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] pattern;
  logic [N-1:0] expv;
  logic         func_val;
  logic [3:0]   cap_cycles;
  logic         scan_out;
  logic         scan_en, scan_in, in_f, busy, done, fail;
  logic [N-1:0] response;
  logic [7:0]   pat_count;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]  signature;
`endif

  logic [N-1:0] chain_q = '0;
  int n_cmp = 0;
  int n_err = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .reset(reset), .start_i(start), .pattern_i(pattern),
    .expect_i(expv), .func_val_i(func_val), .cap_cycles_i(cap_cycles),
    .scan_out_i(scan_out), .scan_en_o(scan_en), .scan_in_o(scan_in),
    .in_o(in_f), .busy_o(busy), .done_o(done), .response_o(response),
    .fail_o(fail), .pat_count_o(pat_count)
`ifdef SCAN_CTRL_MISR_EN
    , .signature_o(signature)
`endif
  );

  // Scan chain environment model
  assign scan_out = chain_q[N-1];
  always @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
    else         chain_q <= chain_q ^ {N{in_f}};
  end

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] exp;
    logic         fv;
    logic [3:0]   cap;
    logic [N-1:0] rsp;
    logic         fl;
    int           dcyc;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each capture clock inverts every flop when func_val is 1
  function automatic logic [N-1:0] ref_rsp(input logic [N-1:0] p, input logic fv, input logic [3:0] cap);
    int c;
    c = (cap == 0) ? 1 : int'(cap);
    return (fv && (c % 2 == 1)) ? ~p : p;
  endfunction

  function automatic logic [15:0] ref_sig(input logic [15:0] s, input logic [N-1:0] r);
    logic [15:0] v;
    v = s;
    for (int i = N - 1; i >= 0; i--)
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ r[i]};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
  endtask

  task automatic run_pass(input logic [N-1:0] p, input logic [N-1:0] e, input logic fv,
                          input logic [3:0] cap, output int dcyc);
    @(negedge clk);
    pattern = p; expv = e; func_val = fv; cap_cycles = cap; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = -1;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (done) begin
        dcyc = t;
        break;
      end
      @(posedge clk);
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
    else model_cnt = (model_cnt + 1) % 256;
  endtask

  initial begin
    int d;
    int dq[$];
    logic [N-1:0] rp, re, rr;
    logic rfv;
    logic [3:0] rc;
    logic [15:0] s_ref, s_zero;

    tbl[0] = '{pat: 2'b10, exp: 2'b10, fv: 1'b0, cap: 4'd1, rsp: 2'b10, fl: 1'b0, dcyc: 7};
    tbl[1] = '{pat: 2'b10, exp: 2'b10, fv: 1'b1, cap: 4'd1, rsp: 2'b01, fl: 1'b1, dcyc: 7};
    tbl[2] = '{pat: 2'b01, exp: 2'b01, fv: 1'b1, cap: 4'd2, rsp: 2'b01, fl: 1'b0, dcyc: 8};
    tbl[3] = '{pat: 2'b01, exp: 2'b01, fv: 1'b1, cap: 4'd0, rsp: 2'b10, fl: 1'b1, dcyc: 7};

    reset = 1'b1; start = 1'b0; pattern = '0; expv = '0; func_val = 1'b0; cap_cycles = '0;
    do_reset();
    chk("rst_scan_en", 32'(scan_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_response", 32'(response), 0);
    chk("rst_pat_count", 32'(pat_count), 0);

    for (int i = 0; i < 4; i++) begin
      run_pass(tbl[i].pat, tbl[i].exp, tbl[i].fv, tbl[i].cap, d);
      chk($sformatf("tbl%0d_done_cycle", i), 32'(d), 32'(tbl[i].dcyc));
      chk($sformatf("tbl%0d_response", i), 32'(response), 32'(tbl[i].rsp));
      chk($sformatf("tbl%0d_fail", i), 32'(fail), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d_pat_count", i), 32'(pat_count), 32'(model_cnt));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle_busy", i), 32'(busy), 0);
      chk($sformatf("tbl%0d_idle_done", i), 32'(done), 0);
    end

    // start held high: exactly one pass at a time, next accepted right after DONE
    @(negedge clk);
    pattern = 2'b10; expv = 2'b10; func_val = 1'b0; cap_cycles = 4'd1; start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (done) dq.push_back(t);
      @(posedge clk);
    end
    start = 1'b0;
    chk("hold_done_count", 32'(dq.size()), 2);
    if (dq.size() >= 2) begin
      chk("hold_first_done", 32'(dq[0]), 7);
      chk("hold_second_done", 32'(dq[1]), 15);
    end

    // reset in the 2nd UNLOAD cycle (cycle N+C+2 = 5)
    do_reset();
    run_pass(2'b10, 2'b10, 1'b0, 4'd1, d);
    @(negedge clk);
    pattern = 2'b11; expv = 2'b11; func_val = 1'b0; cap_cycles = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t < 5; t++) @(negedge clk);
    @(negedge clk);
    chk("midrst_unload_scan_en", 32'(scan_en), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    chk("midrst_scan_en", 32'(scan_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_response", 32'(response), 0);
    chk("midrst_pat_count", 32'(pat_count), 0);
    run_pass(2'b01, 2'b01, 1'b0, 4'd3, d);
    chk("midrst_next_done_cycle", 32'(d), 9);
    chk("midrst_next_response", 32'(response), 32'(2'b01));
    chk("midrst_next_pat_count", 32'(pat_count), 1);

`ifdef SCAN_CTRL_MISR_EN
    do_reset();
    chk("misr_rst", 32'(signature), 0);
    s_ref = '0; s_zero = '0;
    for (int i = 0; i < 2; i++) begin
      run_pass(2'b10, 2'b10, 1'b0, 4'd1, d);
      s_ref  = ref_sig(s_ref, ref_rsp(2'b10, 1'b0, 4'd1));
      s_zero = ref_sig(s_zero, '0);
    end
    chk("misr_signature", 32'(signature), 32'(s_ref));
    n_cmp++;
    if (signature === s_zero) begin
      n_err++;
      $display("FAIL misr_vs_zero: got %0h which must differ from %0h", signature, s_zero);
    end
`endif

    // randomized passes; 256 from reset so the counter wraps back to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rp = N'($urandom); re = N'($urandom); rfv = 1'($urandom); rc = 4'($urandom_range(0, 15));
      rr = ref_rsp(rp, rfv, rc);
      run_pass(rp, re, rfv, rc, d);
      chk("rnd_done_cycle", 32'(d), 32'(2 * N + ((rc == 0) ? 1 : int'(rc)) + 2));
      chk("rnd_response", 32'(response), 32'(rr));
      chk("rnd_fail", 32'(fail), 32'(rr != re));
      chk("rnd_pat_count", 32'(pat_count), 32'(model_cnt));
    end
    chk("wrap_pat_count", 32'(pat_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
